tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequences TLB-maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) from the MEM stage onto the TLB's shared lookup, read and write ports. It arbitrates the data lookup port between ordinary MEM translations and TLBP probes. It also owns the CP0 Random counter used by TLBWR, and returns probe and read results to CP0 through write strobes. It sits between the MEM stage / CP0 and the TLB.

## Interface
Parameters:
- TLB_NUM, 32, number of TLB entries (power of two)
- IDX_W, 5, index width, log2(TLB_NUM)
- VPN2_W, 19, VPN2 width
- ASID_W, 8, ASID width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- op_valid_i  in  1  TLB instruction request
- op_code_i  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready_o  out  1  controller idle; the op is accepted when op_valid_i && op_ready_o && !flush_i
- op_done_o  out  1  one-cycle completion pulse
- flush_i  in  1  pipeline flush
- cp0_vpn2_i  in  VPN2_W  EntryHi.VPN2
- cp0_asid_i  in  ASID_W  EntryHi.ASID
- cp0_index_i  in  IDX_W  Index.Index
- cp0_wired_i  in  IDX_W  Wired
- cp0_wired_we_i  in  1  CP0 write to Wired this cycle
- cp0_index_we_o  out  1  write Index from TLBP
- cp0_index_o  out  IDX_W+1  {P, index}
- cp0_tlbr_we_o  out  1  load EntryHi/Lo0/Lo1/PageMask from the TLB read outputs
- random_o  out  IDX_W  CP0 Random
- mem_req_i  in  1  MEM-stage lookup request
- mem_vpn2_i  in  VPN2_W  MEM lookup VPN2
- mem_odd_i  in  1  MEM lookup odd-page select
- mem_asid_i  in  ASID_W  MEM lookup ASID
- tlb_data_req_o  out  1  to TLB data_tlbReq_i
- tlb_data_vpn2_o  out  VPN2_W  to TLB data_vpn2_i
- tlb_data_odd_o  out  1  to TLB data_oddPage_i
- tlb_data_asid_o  out  ASID_W  to TLB data_asid_i
- tlb_data_hit_i  in  1  from TLB data_hit_o
- tlb_data_index_i  in  IDX_W  from TLB data_index_o
- tlb_w_en_o  out  1  TLB write enable
- tlb_w_index_o  out  IDX_W  TLB write index
- tlb_r_en_o  out  1  TLB read enable
- tlb_r_index_o  out  IDX_W  TLB read index

## Operation
- The FSM has five states: IDLE, P_REQ, P_WAIT, R_WAIT, W_ISSUE. op_ready_o = (state==IDLE).
- Accept transitions from IDLE:
  - TLBP → P_REQ
  - TLBR → R_WAIT, asserting tlb_r_en_o=1 and tlb_r_index_o=cp0_index_i combinationally in the accept cycle
  - TLBWI/TLBWR → W_ISSUE, with the write index latched at accept: cp0_index_i for TLBWI, random_o for TLBWR
- P_REQ: MEM has priority on the data port.
  - If mem_req_i=1, the port passes MEM and P_REQ holds.
  - Otherwise assert tlb_data_req_o with cp0_vpn2_i / cp0_asid_i and odd=0, then go to P_WAIT.
  - flush_i in P_REQ → IDLE, no done pulse.
- P_WAIT: cp0_index_we_o=1 and op_done_o=1, then → IDLE.
  - cp0_index_o = {1'b0, tlb_data_index_i} on hit.
  - cp0_index_o = {1'b1, {IDX_W{0}}} on miss.
  - During P_WAIT the port passes MEM again.
- R_WAIT: cp0_tlbr_we_o=1 and op_done_o=1, then → IDLE.
- W_ISSUE: tlb_w_en_o=1 with the latched index and op_done_o=1, then → IDLE.
- Flush has no effect in P_WAIT, R_WAIT or W_ISSUE: once an op has issued to the TLB, it completes.
- Port mux: when the FSM is not issuing a probe, tlb_data_req_o=mem_req_i and the vpn2/odd/asid outputs follow the mem_* inputs.
- Random counter:
  - Reset value is TLB_NUM-1.
  - If cp0_wired_we_i=1 → TLB_NUM-1.
  - Else if random_o <= cp0_wired_i → TLB_NUM-1. This comparison is unsigned and covers wired ≥ TLB_NUM-1, where the counter holds at TLB_NUM-1.
  - Else decrement by 1 every cycle.
- Reset values: state=IDLE, op_ready_o=1, and every strobe/enable output is 0. cp0_index_o, tlb_w_index_o, tlb_r_index_o and random_o reset to 0, 0, 0 and TLB_NUM-1 respectively.

## Timing
- TLB lookup and read outputs are valid one cycle after the request. P_WAIT and R_WAIT sample in that cycle.
- Latency from accept to op_done_o:
  - TLBP: 2 cycles when the port is free, +1 for each cycle mem_req_i holds the port.
  - TLBR: 1 cycle.
  - TLBWI/TLBWR: 1 cycle, with the write in the same cycle as done.
- Back-to-back ops: the next op can be accepted in the cycle after op_done_o.
- rst asserted mid-op returns to IDLE immediately. No write, read or CP0 strobe may fire after that.
- Simultaneous cp0_wired_we_i and a TLBWR accept: the write uses the pre-update random_o.

## Test plan
- Reset, then count: after 5 cycles with wired=0, random_o=26 (31→26). With wired=28, it wraps 29→28→31.
- TLBP hit: vpn2=0x1234, asid=3, the TLB returns hit at index 7 → cp0_index_o=0x07 and cp0_index_we_o are asserted 2 cycles after accept, together with op_done_o.
- TLBP with contention: mem_req_i held high for 3 cycles → the probe issues in the 4th cycle after accept, and on a miss cp0_index_o=0x20. Flush during the hold → IDLE, with no done and no index write.
- TLBWR: random_o=13 at accept → tlb_w_en_o=1 and tlb_w_index_o=13 one cycle later. A simultaneous cp0_wired_we_i does not change the index.
- TLBR index 9 → tlb_r_en_o in the accept cycle with index 9, then cp0_tlbr_we_o plus done on the next cycle.
- rst asserted in W_ISSUE → no tlb_w_en_o, and op_ready_o=1 immediately.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: runs TLBP/TLBR/TLBWI/TLBWR on the shared TLB ports,
// shares the data lookup port with MEM, and owns the CP0 Random counter.
module tlb_op_ctrl #(
  parameter int TLB_NUM = 32,
  parameter int IDX_W   = 5,
  parameter int VPN2_W  = 19,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic [1:0]        op_code_i,
  output logic              op_ready_o,
  output logic              op_done_o,
  input  logic              flush_i,
  input  logic [VPN2_W-1:0] cp0_vpn2_i,
  input  logic [ASID_W-1:0] cp0_asid_i,
  input  logic [IDX_W-1:0]  cp0_index_i,
  input  logic [IDX_W-1:0]  cp0_wired_i,
  input  logic              cp0_wired_we_i,
  output logic              cp0_index_we_o,
  output logic [IDX_W:0]    cp0_index_o,
  output logic              cp0_tlbr_we_o,
  output logic [IDX_W-1:0]  random_o,
  input  logic              mem_req_i,
  input  logic [VPN2_W-1:0] mem_vpn2_i,
  input  logic              mem_odd_i,
  input  logic [ASID_W-1:0] mem_asid_i,
  output logic              tlb_data_req_o,
  output logic [VPN2_W-1:0] tlb_data_vpn2_o,
  output logic              tlb_data_odd_o,
  output logic [ASID_W-1:0] tlb_data_asid_o,
  input  logic              tlb_data_hit_i,
  input  logic [IDX_W-1:0]  tlb_data_index_i,
  output logic              tlb_w_en_o,
  output logic [IDX_W-1:0]  tlb_w_index_o,
  output logic              tlb_r_en_o,
  output logic [IDX_W-1:0]  tlb_r_index_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_P_REQ, S_P_WAIT, S_R_WAIT, S_W_ISSUE
  } state_e;

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_NUM - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic             accept;
  logic             probe_issue;

  assign op_ready_o    = (state_q == S_IDLE);
  assign accept        = op_valid_i && op_ready_o && !flush_i;
  assign random_o      = rand_q;
  assign tlb_w_index_o = widx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      rand_q  <= RAND_TOP;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      rand_q  <= rand_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    widx_d         = widx_q;
    probe_issue    = 1'b0;
    op_done_o      = 1'b0;
    cp0_index_we_o = 1'b0;
    cp0_index_o    = '0;
    cp0_tlbr_we_o  = 1'b0;
    tlb_w_en_o     = 1'b0;
    tlb_r_en_o     = 1'b0;
    tlb_r_index_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code_i)
            2'b00: state_d = S_P_REQ;
            2'b01: begin
              tlb_r_en_o    = 1'b1;
              tlb_r_index_o = cp0_index_i;
              state_d       = S_R_WAIT;
            end
            2'b10: begin
              widx_d  = cp0_index_i;
              state_d = S_W_ISSUE;
            end
            default: begin
              // Pre-update Random, even if Wired is being written this cycle
              widx_d  = rand_q;
              state_d = S_W_ISSUE;
            end
          endcase
        end
      end
      S_P_REQ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (!mem_req_i) begin
          probe_issue = 1'b1;
          state_d     = S_P_WAIT;
        end
      end
      S_P_WAIT: begin
        cp0_index_we_o = 1'b1;
        op_done_o      = 1'b1;
        cp0_index_o    = tlb_data_hit_i ? {1'b0, tlb_data_index_i}
                                        : {1'b1, {IDX_W{1'b0}}};
        state_d        = S_IDLE;
      end
      S_R_WAIT: begin
        cp0_tlbr_we_o = 1'b1;
        op_done_o     = 1'b1;
        state_d       = S_IDLE;
      end
      S_W_ISSUE: begin
        tlb_w_en_o = 1'b1;
        op_done_o  = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tlb_data_req_o  = probe_issue | mem_req_i;
  assign tlb_data_vpn2_o = probe_issue ? cp0_vpn2_i : mem_vpn2_i;
  assign tlb_data_odd_o  = probe_issue ? 1'b0       : mem_odd_i;
  assign tlb_data_asid_o = probe_issue ? cp0_asid_i : mem_asid_i;

  // Unsigned compare also pins Random at the top when Wired >= TLB_NUM-1
  always_comb begin
    rand_d = rand_q - 1'b1;
    if (cp0_wired_we_i || (rand_q <= cp0_wired_i))
      rand_d = RAND_TOP;
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: Random counter, TLBP with/without contention,
// flush, TLBR, TLBWI/TLBWR and mid-op reset.
module tb_tlb_op_ctrl;
  localparam int TLB_NUM = 32;
  localparam int IDX_W   = 5;
  localparam int VPN2_W  = 19;
  localparam int ASID_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              op_valid_i;
  logic [1:0]        op_code_i;
  logic              op_ready_o, op_done_o, flush_i;
  logic [VPN2_W-1:0] cp0_vpn2_i;
  logic [ASID_W-1:0] cp0_asid_i;
  logic [IDX_W-1:0]  cp0_index_i, cp0_wired_i;
  logic              cp0_wired_we_i, cp0_index_we_o, cp0_tlbr_we_o;
  logic [IDX_W:0]    cp0_index_o;
  logic [IDX_W-1:0]  random_o;
  logic              mem_req_i, mem_odd_i;
  logic [VPN2_W-1:0] mem_vpn2_i;
  logic [ASID_W-1:0] mem_asid_i;
  logic              tlb_data_req_o, tlb_data_odd_o;
  logic [VPN2_W-1:0] tlb_data_vpn2_o;
  logic [ASID_W-1:0] tlb_data_asid_o;
  logic              tlb_data_hit_i;
  logic [IDX_W-1:0]  tlb_data_index_i;
  logic              tlb_w_en_o, tlb_r_en_o;
  logic [IDX_W-1:0]  tlb_w_index_o, tlb_r_index_o;

  int n_chk = 0;
  int n_fail = 0;

  tlb_op_ctrl #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W), .VPN2_W(VPN2_W), .ASID_W(ASID_W)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_code_i(op_code_i), .op_ready_o(op_ready_o),
    .op_done_o(op_done_o), .flush_i(flush_i),
    .cp0_vpn2_i(cp0_vpn2_i), .cp0_asid_i(cp0_asid_i), .cp0_index_i(cp0_index_i),
    .cp0_wired_i(cp0_wired_i), .cp0_wired_we_i(cp0_wired_we_i),
    .cp0_index_we_o(cp0_index_we_o), .cp0_index_o(cp0_index_o),
    .cp0_tlbr_we_o(cp0_tlbr_we_o), .random_o(random_o),
    .mem_req_i(mem_req_i), .mem_vpn2_i(mem_vpn2_i), .mem_odd_i(mem_odd_i),
    .mem_asid_i(mem_asid_i),
    .tlb_data_req_o(tlb_data_req_o), .tlb_data_vpn2_o(tlb_data_vpn2_o),
    .tlb_data_odd_o(tlb_data_odd_o), .tlb_data_asid_o(tlb_data_asid_o),
    .tlb_data_hit_i(tlb_data_hit_i), .tlb_data_index_i(tlb_data_index_i),
    .tlb_w_en_o(tlb_w_en_o), .tlb_w_index_o(tlb_w_index_o),
    .tlb_r_en_o(tlb_r_en_o), .tlb_r_index_o(tlb_r_index_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op_valid_i = 1'b0; op_code_i = 2'b00; flush_i = 1'b0;
    cp0_vpn2_i = '0; cp0_asid_i = '0; cp0_index_i = '0; cp0_wired_i = '0;
    cp0_wired_we_i = 1'b0; mem_req_i = 1'b0; mem_vpn2_i = '0; mem_odd_i = 1'b0;
    mem_asid_i = '0; tlb_data_hit_i = 1'b0; tlb_data_index_i = '0;
    #2;
    chk("rst_ready",  32'(op_ready_o), 32'd1);
    chk("rst_random", 32'(random_o), 32'd31);
    chk("rst_strobes", 32'({op_done_o, cp0_index_we_o, cp0_tlbr_we_o, tlb_w_en_o, tlb_r_en_o}), 32'd0);
    chk("rst_idx", 32'({cp0_index_o, tlb_w_index_o, tlb_r_index_o}), 32'd0);
    tick();
    rst = 1'b0;

    // Random counts down from 31
    repeat (5) tick();
    chk("rand_5cyc", 32'(random_o), 32'd26);

    // Wired=28: 31,30,29,28 then back to 31
    cp0_wired_we_i = 1'b1; tick();
    chk("rand_wired_we", 32'(random_o), 32'd31);
    cp0_wired_we_i = 1'b0; cp0_wired_i = 5'd28;
    tick(); chk("rand_30", 32'(random_o), 32'd30);
    tick(); chk("rand_29", 32'(random_o), 32'd29);
    tick(); chk("rand_28", 32'(random_o), 32'd28);
    tick(); chk("rand_wrap", 32'(random_o), 32'd31);
    cp0_wired_i = 5'd31;
    tick(); chk("rand_hold", 32'(random_o), 32'd31);
    cp0_wired_i = 5'd0;

    // TLBP hit, free port
    op_valid_i = 1'b1; op_code_i = 2'b00; cp0_vpn2_i = 19'h1234; cp0_asid_i = 8'd3;
    #1 chk("p_acc_ready", 32'(op_ready_o), 32'd1);
    chk("p_acc_noreq", 32'(tlb_data_req_o), 32'd0);
    tick(); op_valid_i = 1'b0;
    #1 chk("p_req", 32'(tlb_data_req_o), 32'd1);
    chk("p_req_vpn2", 32'(tlb_data_vpn2_o), 32'h1234);
    chk("p_req_asid", 32'(tlb_data_asid_o), 32'd3);
    chk("p_req_odd",  32'(tlb_data_odd_o), 32'd0);
    chk("p_req_nodone", 32'(op_done_o), 32'd0);
    tick();
    tlb_data_hit_i = 1'b1; tlb_data_index_i = 5'd7;
    mem_req_i = 1'b1; mem_vpn2_i = 19'h55;
    #1 chk("p_hit_we",   32'(cp0_index_we_o), 32'd1);
    chk("p_hit_idx",  32'(cp0_index_o), 32'h07);
    chk("p_hit_done", 32'(op_done_o), 32'd1);
    chk("p_wait_mem", 32'(tlb_data_vpn2_o), 32'h55);
    tick(); mem_req_i = 1'b0; tlb_data_hit_i = 1'b0;
    #1 chk("p_back_idle", 32'(op_ready_o), 32'd1);
    chk("p_we_clr", 32'(cp0_index_we_o), 32'd0);

    // TLBP with MEM holding the port for 3 cycles, then miss
    op_valid_i = 1'b1; op_code_i = 2'b00;
    tick(); op_valid_i = 1'b0; mem_req_i = 1'b1; mem_vpn2_i = 19'hABC; mem_odd_i = 1'b1;
    #1 chk("pc_mem_vpn2", 32'(tlb_data_vpn2_o), 32'hABC);
    chk("pc_mem_odd", 32'(tlb_data_odd_o), 32'd1);
    tick(); #1 chk("pc_hold2", 32'({op_done_o, op_ready_o}), 32'd0);
    tick(); #1 chk("pc_hold3", 32'({op_done_o, op_ready_o}), 32'd0);
    tick(); mem_req_i = 1'b0; mem_odd_i = 1'b0;
    #1 chk("pc_issue_vpn2", 32'(tlb_data_vpn2_o), 32'h1234);
    chk("pc_issue_req", 32'(tlb_data_req_o), 32'd1);
    tick();
    #1 chk("pc_miss_idx", 32'(cp0_index_o), 32'h20);
    chk("pc_miss_done", 32'({op_done_o, cp0_index_we_o}), 32'd3);
    tick();

    // Flush while waiting for the port
    op_valid_i = 1'b1; op_code_i = 2'b00;
    tick(); op_valid_i = 1'b0; mem_req_i = 1'b1;
    tick(); flush_i = 1'b1;
    #1 chk("fl_in_preq", 32'(op_ready_o), 32'd0);
    tick(); flush_i = 1'b0; mem_req_i = 1'b0;
    #1 chk("fl_idle", 32'(op_ready_o), 32'd1);
    chk("fl_nodone", 32'({op_done_o, cp0_index_we_o}), 32'd0);

    // Flush in the accept cycle blocks acceptance
    op_valid_i = 1'b1; op_code_i = 2'b10; flush_i = 1'b1;
    tick(); op_valid_i = 1'b0; flush_i = 1'b0;
    #1 chk("fl_acc_blocked", 32'({op_ready_o, tlb_w_en_o}), 32'd2);

    // TLBR index 9
    cp0_index_i = 5'd9; op_valid_i = 1'b1; op_code_i = 2'b01;
    #1 chk("r_en", 32'(tlb_r_en_o), 32'd1);
    chk("r_idx", 32'(tlb_r_index_o), 32'd9);
    tick(); op_valid_i = 1'b0;
    #1 chk("r_we_done", 32'({cp0_tlbr_we_o, op_done_o, tlb_r_en_o}), 32'b110);

    // TLBWI index 5, then a back-to-back accept after done
    tick(); cp0_index_i = 5'd5; op_valid_i = 1'b1; op_code_i = 2'b10;
    tick(); op_valid_i = 1'b0;
    #1 chk("wi_en", 32'({tlb_w_en_o, op_done_o}), 32'd3);
    chk("wi_idx", 32'(tlb_w_index_o), 32'd5);
    tick();

    // TLBWR with Random at 13 and a simultaneous Wired write
    cp0_wired_we_i = 1'b1; tick(); cp0_wired_we_i = 1'b0;
    repeat (18) tick();
    op_valid_i = 1'b1; op_code_i = 2'b11; cp0_wired_we_i = 1'b1;
    #1 chk("wr_rand13", 32'(random_o), 32'd13);
    tick(); op_valid_i = 1'b0; cp0_wired_we_i = 1'b0;
    #1 chk("wr_en", 32'({tlb_w_en_o, op_done_o}), 32'd3);
    chk("wr_idx", 32'(tlb_w_index_o), 32'd13);
    chk("wr_rand_reset", 32'(random_o), 32'd31);
    tick();

    // Reset asserted while in W_ISSUE
    cp0_index_i = 5'd4; op_valid_i = 1'b1; op_code_i = 2'b10;
    tick(); op_valid_i = 1'b0;
    rst = 1'b1;
    #1 chk("rst_mid_wen", 32'({tlb_w_en_o, op_done_o}), 32'd0);
    chk("rst_mid_ready", 32'(op_ready_o), 32'd1);
    #1 rst = 1'b0;
    tick();
    chk("rst_mid_after", 32'({op_ready_o, tlb_w_en_o, op_done_o}), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
